// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle between the fetch unit and its neighbours:
// program counter, instruction memory, decode and the branch unit.
interface instr_fetch_unit_if #(
  parameter int unsigned AddressWidth = 12,
  parameter int unsigned InstrWidth   = 16
);
  logic [AddressWidth-1:0] PCValue;
  logic                    PCEnable;
  logic                    PCLoadEnable;
  logic [AddressWidth-1:0] PCLoadData;
  logic                    MemReq;
  logic [AddressWidth-1:0] MemAddr;
  logic                    MemAck;
  logic [InstrWidth-1:0]   MemData;
  logic                    InstrValid;
  logic [InstrWidth-1:0]   Instr;
  logic [AddressWidth-1:0] InstrAddr;
  logic                    InstrReady;
  logic                    BranchTaken;
  logic [AddressWidth-1:0] BranchTarget;

  modport master (
    input  PCValue, MemAck, MemData, InstrReady, BranchTaken, BranchTarget,
    output PCEnable, PCLoadEnable, PCLoadData, MemReq, MemAddr,
           InstrValid, Instr, InstrAddr
  );

  modport slave (
    output PCValue, MemAck, MemData, InstrReady, BranchTaken, BranchTarget,
    input  PCEnable, PCLoadEnable, PCLoadData, MemReq, MemAddr,
           InstrValid, Instr, InstrAddr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction read, a 2-entry instruction
// queue for decode, and PC increment/redirect control.
module instr_fetch_unit #(
  parameter int unsigned AddressWidth = 12,
  parameter int unsigned InstrWidth   = 16
) (
  input logic               CLK,
  input logic               Reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, FLUSH} state_t;

  state_t                  r_state;
  logic                    r_mem_req;
  logic [AddressWidth-1:0] r_mem_addr;
  logic [InstrWidth-1:0]   r_q_instr [2];
  logic [AddressWidth-1:0] r_q_addr  [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_pc_en;
  logic                    w_pc_load;
  logic [AddressWidth-1:0] w_pc_data;

  // A redirect in the ack cycle wins: the data is dropped and the PC loads the target.
  assign w_push = (r_state == WAIT_MEM) && bus.MemAck && !bus.BranchTaken;
  assign w_pop  = (r_count != 2'd0) && bus.InstrReady;

  always_comb begin
    w_pc_en   = 1'b0;
    w_pc_load = 1'b0;
    w_pc_data = '0;
    if (Reset) begin
      if (bus.BranchTaken) begin
        w_pc_en   = 1'b1;
        w_pc_load = 1'b1;
        w_pc_data = bus.BranchTarget;
      end else if (w_push) begin
        w_pc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.BranchTaken && (r_count < 2'd2)) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= bus.PCValue;
            r_state    <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (bus.MemAck) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end else if (bus.BranchTaken) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (bus.MemAck) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (bus.BranchTaken) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; InstrValid qualifies it.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= bus.MemData;
      r_q_addr[r_wr_ptr]  <= r_mem_addr;
    end
  end

  assign bus.MemReq       = r_mem_req;
  assign bus.MemAddr      = r_mem_addr;
  assign bus.InstrValid   = (r_count != 2'd0);
  assign bus.Instr        = r_q_instr[r_rd_ptr];
  assign bus.InstrAddr    = r_q_addr[r_rd_ptr];
  assign bus.PCEnable     = w_pc_en;
  assign bus.PCLoadEnable = w_pc_load;
  assign bus.PCLoadData   = w_pc_data;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small program-counter model
// driven by the fetch unit's PC control outputs.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic [11:0] pc;
  logic        pc_set;
  logic [11:0] pc_set_val;
  int          total;
  int          bad;

  instr_fetch_unit_if #(.AddressWidth(12), .InstrWidth(16)) bus ();

  instr_fetch_unit #(.AddressWidth(12), .InstrWidth(16)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External program counter: +2 on enable, load on load-enable.
  always_ff @(posedge CLK) begin
    if (pc_set)            pc <= pc_set_val;
    else if (bus.PCEnable) pc <= bus.PCLoadEnable ? bus.PCLoadData : pc + 12'd2;
  end
  assign bus.PCValue = pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic ack, input logic [15:0] d, input logic rdy,
                      input logic br, input logic [11:0] tgt);
    @(negedge CLK);
    bus.MemAck       = ack;
    bus.MemData      = d;
    bus.InstrReady   = rdy;
    bus.BranchTaken  = br;
    bus.BranchTarget = tgt;
    #1;
  endtask

  task automatic do_reset(input logic [11:0] v);
    @(negedge CLK);
    Reset            = 1'b0;
    pc_set           = 1'b1;
    pc_set_val       = v;
    bus.MemAck       = 1'b0;
    bus.MemData      = '0;
    bus.InstrReady   = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = '0;
    @(negedge CLK);
    pc_set = 1'b0;
    Reset  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    Reset            = 1'b0;
    pc_set           = 1'b1;
    pc_set_val       = 12'h000;
    bus.MemAck       = 1'b0;
    bus.MemData      = '0;
    bus.InstrReady   = 1'b0;
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 12'h555;
    @(negedge CLK); #1;
    chk("rst_memreq",  32'(bus.MemReq),       32'h0);
    chk("rst_memaddr", 32'(bus.MemAddr),      32'h0);
    chk("rst_valid",   32'(bus.InstrValid),   32'h0);
    chk("rst_pcen",    32'(bus.PCEnable),     32'h0);
    chk("rst_pcld",    32'(bus.PCLoadEnable), 32'h0);
    chk("rst_pcdata",  32'(bus.PCLoadData),   32'h0);

    // Sequential fetch with decode always ready
    do_reset(12'h000);
    tick(1'b1, 16'hA000, 1'b1, 1'b0, 12'h0);
    chk("t1_req0",   32'(bus.MemReq),       32'h1);
    chk("t1_addr0",  32'(bus.MemAddr),      32'h000);
    chk("t1_pcen0",  32'(bus.PCEnable),     32'h1);
    chk("t1_pcld0",  32'(bus.PCLoadEnable), 32'h0);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 12'h0);
    chk("t1_val0",   32'(bus.InstrValid),   32'h1);
    chk("t1_iaddr0", 32'(bus.InstrAddr),    32'h000);
    chk("t1_instr0", 32'(bus.Instr),        32'hA000);
    chk("t1_pcidle", 32'(bus.PCEnable),     32'h0);
    tick(1'b1, 16'hA002, 1'b1, 1'b0, 12'h0);
    chk("t1_addr1",  32'(bus.MemAddr),      32'h002);
    chk("t1_val1",   32'(bus.InstrValid),   32'h0);
    chk("t1_pcen1",  32'(bus.PCEnable),     32'h1);
    chk("t1_pcld1",  32'(bus.PCLoadEnable), 32'h0);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 12'h0);
    chk("t1_iaddr1", 32'(bus.InstrAddr),    32'h002);
    chk("t1_instr1", 32'(bus.Instr),        32'hA002);
    tick(1'b1, 16'hA004, 1'b1, 1'b0, 12'h0);
    chk("t1_addr2",  32'(bus.MemAddr),      32'h004);
    chk("t1_pcen2",  32'(bus.PCEnable),     32'h1);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t1_iaddr2", 32'(bus.InstrAddr),    32'h004);
    chk("t1_instr2", 32'(bus.Instr),        32'hA004);
    chk("t1_pcld2",  32'(bus.PCLoadEnable), 32'h0);

    // Queue fills with decode stalled, then drains; push+pop at count 1
    do_reset(12'h000);
    tick(1'b1, 16'hB000, 1'b0, 1'b0, 12'h0);
    chk("t2_addr0",  32'(bus.MemAddr),    32'h000);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t2_val0",   32'(bus.InstrValid), 32'h1);
    chk("t2_head0",  32'(bus.InstrAddr),  32'h000);
    tick(1'b1, 16'hB002, 1'b0, 1'b0, 12'h0);
    chk("t2_req1",   32'(bus.MemReq),     32'h1);
    chk("t2_addr1",  32'(bus.MemAddr),    32'h002);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t2_full_a", 32'(bus.MemReq),     32'h0);
    chk("t2_head_a", 32'(bus.InstrAddr),  32'h000);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t2_full_b", 32'(bus.MemReq),     32'h0);
    chk("t2_val_b",  32'(bus.InstrValid), 32'h1);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 12'h0);
    chk("t2_pop0_a", 32'(bus.InstrAddr),  32'h000);
    chk("t2_pop0_i", 32'(bus.Instr),      32'hB000);
    chk("t2_full_c", 32'(bus.MemReq),     32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t2_noreq",  32'(bus.MemReq),     32'h0);
    chk("t2_head1",  32'(bus.InstrAddr),  32'h002);
    chk("t2_instr1", 32'(bus.Instr),      32'hB002);
    tick(1'b1, 16'hB004, 1'b1, 1'b0, 12'h0);
    chk("t2_req3",   32'(bus.MemReq),     32'h1);
    chk("t2_addr3",  32'(bus.MemAddr),    32'h004);
    chk("t2_head1b", 32'(bus.InstrAddr),  32'h002);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 12'h0);
    chk("t5_val",    32'(bus.InstrValid), 32'h1);
    chk("t5_head",   32'(bus.InstrAddr),  32'h004);
    chk("t5_instr",  32'(bus.Instr),      32'hB004);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t5_empty",  32'(bus.InstrValid), 32'h0);
    chk("t5_req",    32'(bus.MemReq),     32'h1);
    chk("t5_addr",   32'(bus.MemAddr),    32'h006);

    // Redirect while waiting on memory; stale ack is flushed
    do_reset(12'h010);
    tick(1'b1, 16'hC010, 1'b0, 1'b0, 12'h0);
    chk("t3_addr0",  32'(bus.MemAddr),      32'h010);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t3_val0",   32'(bus.InstrValid),   32'h1);
    tick(1'b0, 16'h0, 1'b0, 1'b1, 12'h100);
    chk("t3_addr1",  32'(bus.MemAddr),      32'h012);
    chk("t3_pcen",   32'(bus.PCEnable),     32'h1);
    chk("t3_pcld",   32'(bus.PCLoadEnable), 32'h1);
    chk("t3_pcdata", 32'(bus.PCLoadData),   32'h100);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t3_flushv", 32'(bus.InstrValid),   32'h0);
    chk("t3_flreq",  32'(bus.MemReq),       32'h1);
    chk("t3_fladdr", 32'(bus.MemAddr),      32'h012);
    chk("t3_flpc",   32'(bus.PCEnable),     32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t3_flreq2", 32'(bus.MemReq),       32'h1);
    tick(1'b1, 16'hDEAD, 1'b0, 1'b0, 12'h0);
    chk("t3_staleen", 32'(bus.PCEnable),    32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t3_idlereq", 32'(bus.MemReq),      32'h0);
    chk("t3_nopush",  32'(bus.InstrValid),  32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t3_newreq",  32'(bus.MemReq),      32'h1);
    chk("t3_newaddr", 32'(bus.MemAddr),     32'h100);

    // Redirect coincident with ack, then redirect from IDLE
    tick(1'b1, 16'hE100, 1'b0, 1'b0, 12'h0);
    chk("t4_pcen0",  32'(bus.PCEnable),     32'h1);
    chk("t4_pcld0",  32'(bus.PCLoadEnable), 32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t4_head",   32'(bus.InstrAddr),    32'h100);
    tick(1'b1, 16'hBAD0, 1'b0, 1'b1, 12'h200);
    chk("t4_addr",   32'(bus.MemAddr),      32'h102);
    chk("t4_pcen",   32'(bus.PCEnable),     32'h1);
    chk("t4_pcld",   32'(bus.PCLoadEnable), 32'h1);
    chk("t4_pcdata", 32'(bus.PCLoadData),   32'h200);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t4_nopush", 32'(bus.InstrValid),   32'h0);
    chk("t4_idle",   32'(bus.MemReq),       32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t4_newaddr", 32'(bus.MemAddr),     32'h200);
    tick(1'b1, 16'hF200, 1'b0, 1'b0, 12'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b1, 12'h300);
    chk("ti_req",    32'(bus.MemReq),       32'h0);
    chk("ti_val",    32'(bus.InstrValid),   32'h1);
    chk("ti_pcld",   32'(bus.PCLoadEnable), 32'h1);
    chk("ti_pcdata", 32'(bus.PCLoadData),   32'h300);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("ti_noreq",  32'(bus.MemReq),       32'h0);
    chk("ti_empty",  32'(bus.InstrValid),   32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("ti_addr",   32'(bus.MemAddr),      32'h300);

    // Asynchronous reset in WAIT_MEM with a non-empty queue
    tick(1'b1, 16'h1300, 1'b0, 1'b0, 12'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t6_val",    32'(bus.InstrValid),   32'h1);
    chk("t6_head",   32'(bus.InstrAddr),    32'h300);
    @(negedge CLK);
    bus.MemAck = 1'b1;
    #1;
    chk("t6_pre_en",  32'(bus.PCEnable),    32'h1);
    chk("t6_pre_req", 32'(bus.MemReq),      32'h1);
    chk("t6_pre_adr", 32'(bus.MemAddr),     32'h302);
    #1 Reset = 1'b0;
    #1;
    chk("t6_req",    32'(bus.MemReq),       32'h0);
    chk("t6_addr",   32'(bus.MemAddr),      32'h0);
    chk("t6_valid",  32'(bus.InstrValid),   32'h0);
    chk("t6_pcen",   32'(bus.PCEnable),     32'h0);
    @(negedge CLK);
    bus.MemAck = 1'b0;
    Reset      = 1'b1;
    #1;
    chk("t6_rel",    32'(bus.MemReq),       32'h0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 12'h0);
    chk("t6_req2",   32'(bus.MemReq),       32'h1);
    chk("t6_addr2",  32'(bus.MemAddr),      32'h302);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
